// File: rtl/pipeline_perf_monitor.sv
// Performance monitor: counts cycles and event strobes during a run, stops at MAX_CYCLES,
// registered select/read port. Optional counter saturation enabled by PERF_MON_SAT_EN.
module pipeline_perf_monitor #(
   parameter int unsigned NUM_EVT    = 4,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned SEL_W      = 4,
   parameter int unsigned MAX_CYCLES = 500
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               clear,
   input  logic [NUM_EVT-1:0] evt_i,
   input  logic               rd_en_i,
   input  logic [SEL_W-1:0]   rd_sel_i,
   output logic [CNT_W-1:0]   rd_data_o,
   output logic               rd_valid_o,
   output logic [CNT_W-1:0]   cycle_o,
   output logic               running_o,
   output logic               limit_hit_o,
   output logic [NUM_EVT:0]   sat_o
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             running_q, running_d;
   logic             limit_q, limit_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] evt_cnt_q [NUM_EVT];
   logic [CNT_W-1:0] evt_cnt_d [NUM_EVT];
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic [CNT_W-1:0] rd_mux;
   logic             count_en;
`ifdef PERF_MON_SAT_EN
   logic [NUM_EVT:0] sat_q, sat_d;
`endif

   // The edge that takes IDLE into RUN already counts, so counting keys off start, not state.
   assign count_en = !clear && start && (state_q != ST_DONE);

   // Counter next-values
   always_comb begin
      cycle_d = cycle_q;
      for (int k = 0; k < NUM_EVT; k++) evt_cnt_d[k] = evt_cnt_q[k];
`ifdef PERF_MON_SAT_EN
      sat_d = sat_q;
      if (count_en) begin
         if (&cycle_q) sat_d[NUM_EVT] = 1'b1;
         else          cycle_d = cycle_q + CNT_W'(1);
         for (int k = 0; k < NUM_EVT; k++) begin
            if (evt_i[k]) begin
               if (&evt_cnt_q[k]) sat_d[k] = 1'b1;
               else               evt_cnt_d[k] = evt_cnt_q[k] + CNT_W'(1);
            end
         end
      end
      if (clear) sat_d = '0;
`else
      if (count_en) begin
         cycle_d = cycle_q + CNT_W'(1);
         for (int k = 0; k < NUM_EVT; k++) begin
            if (evt_i[k]) evt_cnt_d[k] = evt_cnt_q[k] + CNT_W'(1);
         end
      end
`endif
      if (clear) begin
         cycle_d = '0;
         for (int k = 0; k < NUM_EVT; k++) evt_cnt_d[k] = '0;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start) state_d = (cycle_d == MAX_C) ? ST_DONE : ST_RUN;
            ST_RUN: begin
               if (!start)                 state_d = ST_IDLE;
               else if (cycle_d == MAX_C)  state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Status outputs decoded from the next state so they leave straight from flops
   always_comb begin
      running_d = 1'b0;
      limit_d   = 1'b0;
      case (state_d)
         ST_RUN:  running_d = 1'b1;
         ST_DONE: limit_d   = 1'b1;
         default: ;
      endcase
   end

   // Read mux returns the pre-increment value; out-of-range selects read as zero
   always_comb begin
      rd_mux = '0;
      for (int k = 0; k < NUM_EVT; k++) begin
         if (rd_sel_i == SEL_W'(k)) rd_mux = evt_cnt_q[k];
      end
      if (rd_sel_i == SEL_W'(NUM_EVT)) rd_mux = cycle_q;
   end

   always_comb begin
      rd_valid_d = rd_en_i;
      rd_data_d  = rd_en_i ? rd_mux : rd_data_q;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         running_q <= 1'b0;
         limit_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= running_d;
         limit_q   <= limit_d;
      end
   end

   // Counter and read-port registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q    <= '0;
         for (int k = 0; k < NUM_EVT; k++) evt_cnt_q[k] <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
`ifdef PERF_MON_SAT_EN
         sat_q      <= '0;
`endif
      end else begin
         cycle_q    <= cycle_d;
         for (int k = 0; k < NUM_EVT; k++) evt_cnt_q[k] <= evt_cnt_d[k];
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
`ifdef PERF_MON_SAT_EN
         sat_q      <= sat_d;
`endif
      end
   end

   assign rd_data_o   = rd_data_q;
   assign rd_valid_o  = rd_valid_q;
   assign cycle_o     = cycle_q;
   assign running_o   = running_q;
   assign limit_hit_o = limit_q;
`ifdef PERF_MON_SAT_EN
   assign sat_o       = sat_q;
`else
   assign sat_o       = '0;
`endif

endmodule
